// File: rtl/ram_arbiter_n.sv
// ram_arbiter_n: NPORT-way arbiter serialising byte/half/word accesses onto a byte-wide RAM/IO bus.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise the highest requesting port wins.
module ram_arbiter_n #(
    parameter int          NPORT   = 2,
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NPORT-1:0]      req,
    input  logic [NPORT-1:0]      we,
    input  logic [NPORT*32-1:0]   addr,
    input  logic [NPORT*2-1:0]    size,
    input  logic [NPORT*32-1:0]   wdata,
    input  logic [NPORT-1:0]      abort,
    output logic [31:0]           rdata,
    output logic [NPORT-1:0]      done,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    localparam int GW = (NPORT > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;

    state_t           state, state_d;
    logic [GW-1:0]    grant, pick;
    logic             found;
    logic [NPORT-1:0] elig;
    logic [31:0]      addr_q, wdata_q, rbuf;
    logic             we_q, io_q, gap;
    logic [2:0]       k, nbytes;
    logic [1:0]       sel_size;
    logic             issue, last, abort_g;

    assign elig     = req & ~abort;
    assign sel_size = size[pick*2 +: 2];
    assign abort_g  = abort[grant];
    assign last     = (k == nbytes - 3'd1);
    assign issue    = (state == XFER) && (!we_q || !io_q || (!gap && !io_buffer_full));

`ifdef RAM_ARB_RR_EN
    logic [GW-1:0] ptr;

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in)
            ptr <= '0;
        else if (state != IDLE && state_d == IDLE)
            ptr <= (int'(grant) == NPORT - 1) ? '0 : grant + 1'b1;

    // search starts at the port after the one served last
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NPORT; i++)
            if (!found && elig[(int'(ptr) + i) % NPORT]) begin
                found = 1'b1;
                pick  = GW'((int'(ptr) + i) % NPORT);
            end
    end
`else
    always_comb begin
        found = |elig;
        pick  = '0;
        for (int i = 0; i < NPORT; i++)
            if (elig[i]) pick = GW'(i);
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) state <= IDLE;
        else         state <= state_d;

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: state_d = found ? XFER : IDLE;
            XFER: state_d = (!we_q && abort_g) ? IDLE : (issue && last) ? (we_q ? DONE : TAIL) : XFER;
            TAIL: state_d = abort_g ? IDLE : DONE;
            DONE: state_d = IDLE;
        endcase
        mem_wr   = issue && we_q;
        mem_a    = issue ? addr_q + {29'd0, k} : '0;
        mem_dout = (issue && we_q) ? wdata_q[{k[1:0], 3'b000} +: 8] : '0;
        done     = (state == DONE) ? NPORT'(1) << grant : '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            grant   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            nbytes  <= 3'd1;
            k       <= '0;
            gap     <= 1'b0;
            rbuf    <= '0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant   <= pick;
                addr_q  <= addr[pick*32 +: 32];
                wdata_q <= wdata[pick*32 +: 32];
                we_q    <= we[pick];
                io_q    <= we[pick] && (addr[pick*32 +: 32] >= IO_BASE);
                nbytes  <= (sel_size == 2'd0) ? 3'd1 : (sel_size == 2'd1) ? 3'd2 : 3'd4;
                k       <= '0;
                gap     <= 1'b0;
                rbuf    <= '0;
            end
            if (issue)
                k <= k + 3'd1;
            // an idle cycle after each IO byte lets io_buffer_full catch up
            if (state == XFER && io_q)
                gap <= issue && !last;
            if (state == XFER && !we_q && k != 3'd0)
                rbuf[{k[1:0] - 2'd1, 3'b000} +: 8] <= mem_din;
            if (state == TAIL && state_d == DONE)
                rdata <= rbuf | ({24'd0, mem_din} << {nbytes[1:0] - 2'd1, 3'b000});
            else if (state == XFER && state_d == DONE)
                rdata <= '0;
        end
    end
endmodule

// File: tb/tb_ram_arbiter_n.sv
// tb_ram_arbiter_n: directed and random transactions against a transaction-level model of ram_arbiter_n.
// Arbitration expectations follow RAM_ARB_RR_EN when it is defined.
module tb_ram_arbiter_n;
    localparam int          NPORT   = 2;
    localparam logic [31:0] IO_BASE = 32'h00030000;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b0;
    logic [NPORT-1:0]    req = '0, we = '0, abort = '0, done;
    logic [NPORT*32-1:0] addr = '0, wdata = '0;
    logic [NPORT*2-1:0]  size = '0;
    logic [31:0]         rdata, mem_a;
    logic [7:0]          mem_din = '0, mem_dout, pend = '0;
    logic                mem_wr, io_buffer_full = 1'b0;
    int                  n_checks = 0, n_errors = 0;
    logic [7:0]          ram [logic [31:0]];
    logic [7:0]          ref_mem [logic [31:0]];

    always #5 clk_in = ~clk_in;

    ram_arbiter_n #(.NPORT(NPORT), .IO_BASE(IO_BASE)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req(req), .we(we), .addr(addr), .size(size),
        .wdata(wdata), .abort(abort), .rdata(rdata), .done(done), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    function automatic logic [7:0] seed_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_byte(a);
    endfunction

    // RAM: returns the byte addressed in the previous cycle
    always @(negedge clk_in) begin
        mem_din = pend;
        pend = ram.exists(mem_a) ? ram[mem_a] : seed_byte(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        req = '0; abort = '0; we = '0; io_buffer_full = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
    endtask

    // called 1 time unit after a rising edge; that cycle is cycle 0
    task automatic xact(input int p, input bit w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [63:0] fp);
        int nb, last, c, got_done, nlog;
        int exp_cyc[4];
        int log_c[8];
        logic [31:0] log_a[8];
        logic [7:0] log_d[8];
        logic log_w[8];
        logic [31:0] exp_rd, got_rd;
        logic [NPORT-1:0] got_vec;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = 0; c = 1; exp_rd = '0;
        for (int i = 0; i < nb; i++) begin
            if (w && a >= IO_BASE)
                while (fp[c] || (i > 0 && c == last + 1)) c++;
            exp_cyc[i] = c;
            last = c;
            c++;
            if (w) ref_mem[a + i] = wd[8*i +: 8];
            else   exp_rd[8*i +: 8] = ref_rd(a + i);
        end
        req[p] = 1'b1; we[p] = w; addr[p*32 +: 32] = a; size[p*2 +: 2] = sz; wdata[p*32 +: 32] = wd;
        got_done = -1; nlog = 0; got_vec = '0; got_rd = '0;
        for (int cy = 1; cy < 60 && got_done < 0; cy++) begin
            @(posedge clk_in);
            #1 io_buffer_full = fp[cy];
            @(negedge clk_in);
            if ((mem_wr || mem_a != 0) && nlog < 8) begin
                log_c[nlog] = cy; log_a[nlog] = mem_a; log_d[nlog] = mem_dout; log_w[nlog] = mem_wr;
                nlog++;
            end
            if (done != '0) begin
                got_done = cy; got_vec = done; got_rd = rdata; req[p] = 1'b0;
            end
        end
        req[p] = 1'b0;
        io_buffer_full = 1'b0;
        @(posedge clk_in);
        #1;
        check("done_cycle", got_done, w ? last + 1 : last + 2);
        check("done_port", 32'(got_vec), 32'(1 << p));
        check("rdata", got_rd, w ? 32'd0 : exp_rd);
        check("issue_count", nlog, nb);
        for (int i = 0; i < nb && i < nlog; i++) begin
            check("issue_cycle", log_c[i], exp_cyc[i]);
            check("issue_addr", log_a[i], a + i);
            check("issue_wr", 32'(log_w[i]), 32'(w));
            if (w) check("issue_data", 32'(log_d[i]), 32'(wd[8*i +: 8]));
        end
    endtask

    task automatic arb_test();
        int order[4], cyc[4], exp_order[4];
        int n = 0;
`ifdef RAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{1, 0, 1, 0};
`endif
        order = '{-1, -1, -1, -1};
        cyc = '{-1, -1, -1, -1};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int q = 0; q < NPORT; q++) begin
                req[q] = 1'b1; we[q] = 1'b0; size[q*2 +: 2] = 2'd0;
                addr[q*32 +: 32] = 32'h400 + 32'(q * 16 + r);
            end
            for (int cy = 1; cy < 30 && req != '0; cy++) begin
                @(posedge clk_in);
                #1;
                @(negedge clk_in);
                for (int q = 0; q < NPORT; q++)
                    if (done[q] && n < 4) begin
                        order[n] = q; cyc[n] = cy;
                        check("arb_rdata", rdata, {24'd0, ref_rd(32'h400 + 32'(q * 16 + r))});
                        req[q] = 1'b0;
                        n++;
                    end
            end
            req = '0;
            @(posedge clk_in);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            check("arb_port", order[i], exp_order[i]);
            check("arb_cycle", cyc[i], (i % 2 == 0) ? 3 : 7);
        end
    endtask

    task automatic abort_test();
        int d0 = 0, d1 = -1;
        logic [31:0] rd1 = '0;
        do_reset();
        req[0] = 1'b1; we[0] = 1'b0; size[1:0] = 2'd2; addr[31:0] = 32'h500;
        for (int cy = 1; cy < 20; cy++) begin
            @(posedge clk_in);
            #1;
            if (cy == 1) begin
                req[1] = 1'b1; we[1] = 1'b0; size[3:2] = 2'd0; addr[63:32] = 32'h600;
            end
            abort[0] = (cy == 2);
            if (cy == 2) req[0] = 1'b0;
            @(negedge clk_in);
            if (done[0]) d0++;
            if (done[1] && d1 < 0) begin
                d1 = cy; rd1 = rdata; req[1] = 1'b0;
            end
        end
        req = '0; abort = '0;
        @(posedge clk_in);
        #1;
        check("abort_no_done0", d0, 0);
        check("abort_done1_cycle", d1, 6);
        check("abort_rdata1", rd1, {24'd0, ref_rd(32'h600)});
    endtask

    task automatic idle_abort_test();
        int d = -1;
        req[0] = 1'b1; we[0] = 1'b0; size[1:0] = 2'd0; addr[31:0] = 32'h700; abort[0] = 1'b1;
        for (int cy = 1; cy < 12; cy++) begin
            @(posedge clk_in);
            #1 abort[0] = 1'b0;
            @(negedge clk_in);
            if (done[0] && d < 0) begin
                d = cy; req[0] = 1'b0;
            end
        end
        req = '0;
        @(posedge clk_in);
        #1;
        check("idle_abort_cycle", d, 4);
    endtask

    task automatic reset_test();
        xact(1, 1'b0, 32'h800, 2'd2, 32'd0, 64'd0);
        req[0] = 1'b1; we[0] = 1'b1; size[1:0] = 2'd2; addr[31:0] = 32'h900; wdata[31:0] = 32'h11223344;
        repeat (2) begin
            @(posedge clk_in);
            #1;
        end
        check("pre_reset_wr", 32'(mem_wr), 32'd1);
        ref_mem[32'h900] = 8'h44;
        rst_in = 1'b0;
        #1;
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        req = '0;
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        xact(0, 1'b1, 32'h904, 2'd2, 32'hCAFEF00D, 64'd0);
    endtask

    initial begin
        bit w;
        int p;
        logic [1:0] sz;
        logic [31:0] a, wd;
        logic [63:0] fp;
        #12;
        check("reset_mem_wr", 32'(mem_wr), 32'd0);
        check("reset_mem_a", mem_a, 32'd0);
        check("reset_mem_dout", 32'(mem_dout), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        ram[32'h200] = 8'h34; ram[32'h201] = 8'h12;
        ref_mem[32'h200] = 8'h34; ref_mem[32'h201] = 8'h12;
        xact(0, 1'b1, 32'h100, 2'd2, 32'hDDCCBBAA, 64'd0);
        xact(1, 1'b0, 32'h200, 2'd1, 32'd0, 64'd0);
        xact(0, 1'b1, 32'h30000, 2'd0, 32'h5A, 64'hE);
        xact(1, 1'b1, 32'hFFFFFFFE, 2'd2, 32'h87654321, 64'd0);
        xact(0, 1'b0, 32'h100, 2'd3, 32'd0, 64'd0);
        for (int t = 0; t < 60; t++) begin
            w  = 1'($urandom_range(0, 1));
            p  = $urandom_range(0, NPORT - 1);
            sz = 2'($urandom_range(0, 3));
            a  = (w && $urandom_range(0, 2) == 0) ? IO_BASE + 32'($urandom_range(0, 255))
                                                  : 32'h100 + 32'($urandom_range(0, 32'h3FE00));
            wd = $urandom;
            fp = {24'd0, 40'({$urandom, $urandom} & {$urandom, $urandom})};
            xact(p, w, a, sz, wd, fp);
        end
        arb_test();
        abort_test();
        idle_abort_test();
        reset_test();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter_n.md
RAM_ARBITER_N -- requirements
Module: ram_arbiter_n

Interface
REQ-001 Parameter NPORT, default 2: number of requester ports, legal range 2..4; port 0 has the lowest index.
REQ-002 Parameter IO_BASE, default 32'h00030000: addresses at or above this value are IO space.
REQ-003 clk_in  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_in  in  1  reset, asynchronous, active-low.
REQ-005 req  in  NPORT  per-port request; held high until that port's done.
REQ-006 we  in  NPORT  per-port write enable (1 = write).
REQ-007 addr  in  NPORT*32  per-port byte address.
REQ-008 size  in  NPORT*2  per-port access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-009 wdata  in  NPORT*32  per-port write data, little-endian.
REQ-010 abort  in  NPORT  per-port cancel, for flush on jump.
REQ-011 rdata  out  32  read data, zero-extended, valid while done is high.
REQ-012 done  out  NPORT  one-cycle completion pulse for the granted port.
REQ-013 mem_din  in  8  RAM read byte; returns the byte for the address driven in the previous cycle.
REQ-014 mem_dout  out  8  RAM write byte.
REQ-015 mem_a  out  32  RAM byte address.
REQ-016 mem_wr  out  1  1 = write this cycle.
REQ-017 io_buffer_full  in  1  UART buffer full.

Function
REQ-018 FSM states: IDLE, XFER, TAIL, DONE.
REQ-019 IDLE with any req high and its abort low:
- grant one port;
- latch that port's addr, size, we and wdata;
- set byte index k = 0 and nbytes = 1, 2 or 4;
- go to XFER.
REQ-020 XFER, each cycle, issues byte k:
- mem_a = latched addr + k (32-bit wrap-around);
- write: mem_wr = 1, mem_dout = wdata[8k+7:8k];
- read: mem_wr = 0;
- k increments.
REQ-021 Read byte k is captured from mem_din one cycle after it was issued.
REQ-022 After the last byte is issued, a read goes to TAIL to capture the final byte, then to DONE; a write goes directly to DONE.
REQ-023 DONE drives done[grant] = 1 for exactly one cycle, with rdata = assembled bytes and unused upper bytes 0; the next state is IDLE.
REQ-024 Latency from the edge that samples req:
- word write: done high in cycle 5;
- word read: done high in cycle 6;
- byte read: done high in cycle 3.
REQ-025 When not issuing: mem_wr = 0, mem_a = 0, mem_dout = 0.
REQ-026 IO writes (latched addr >= IO_BASE) issue no byte while io_buffer_full = 1; the FSM holds k and drives mem_wr = 0.
REQ-027 After every issued IO write byte, one cycle with mem_wr = 0 is inserted before the next bus action, to cover the one-cycle lag of io_buffer_full.
REQ-028 abort[grant] during XFER or TAIL of a read returns the FSM to IDLE next cycle, with no done pulse and the grant released.
REQ-029 abort during a write is ignored, so the write always completes.
REQ-030 abort is also honoured in the cycle it is sampled in IDLE: an aborted port is not granted.
REQ-031 If req and done coincide on the same port in the DONE cycle, that request is the already-served one; a new request is eligible from IDLE only.
REQ-032 done and rdata change only in DONE; rdata holds its last value otherwise.

Reset
REQ-033 While rst_in = 0, asynchronously:
- state = IDLE, k = 0, grant = 0;
- the round-robin pointer points to port 0;
- done = 0, rdata = 0, mem_wr = 0, mem_a = 0, mem_dout = 0.
REQ-034 Reset asserted mid-transfer drops the transfer with no done pulse; the first grant after release follows REQ-019.

Configuration
REQ-035 Macro RAM_ARB_RR_EN selects the arbitration policy.
REQ-036 With RAM_ARB_RR_EN defined: round-robin; after port p completes or aborts, the pointer moves to p+1 mod NPORT, and the search for the next grant starts at the pointer.
REQ-037 Without RAM_ARB_RR_EN: fixed priority, highest requesting index wins (port NPORT-1 = MEM stage); there is no pointer state.

Verification
REQ-038 Word write port 0, addr 0x100, wdata 0xDDCCBBAA -> mem_a 0x100..0x103 with mem_dout AA, BB, CC, DD and mem_wr = 1 in cycles 1-4; done[0] in cycle 5.
REQ-039 Half read port 1, addr 0x200, RAM bytes 0x34, 0x12 -> rdata 0x00001234, done[1] in cycle 4.
REQ-040 Both ports request a byte read in the same cycle, repeated twice:
- RR build: grants 0, 1, 0, 1 across four requests;
- fixed build: port 1 is always granted first.
REQ-041 Byte write to 0x30000 with io_buffer_full = 1 for cycles 1-3 -> mem_wr = 0 in cycles 1-3, byte issued in cycle 4, done in cycle 5.
REQ-042 Word read port 0 with abort[0] pulsed in cycle 2 -> no done[0]; a pending port 1 is granted in cycle 3 (IDLE).
REQ-043 rst_in = 0 in cycle 2 of a word write -> all outputs 0 at once; after release, a new request completes normally.
